coll_pair_sched: RTL and testbench
==================================

// Module: coll_pair_sched
// PURPOSE
//  Initiator for coll_det: holds a table of N_OBJ objects (pos/vel), enumerates every pair (i<j) on start,
//  drives one coll_det transaction per pair over its x1..r2/in_rdy/out_rdy/trial interface, streams per-pair
//  results and a hit count. Sits between the object loader and the collision checker.
// PARAMETERS
//  N_OBJ  8  objects in table (>=2); pairs P = N_OBJ*(N_OBJ-1)/2
//  IDX_W  3  object index width, clog2(N_OBJ)
// PORTS
//  clock       in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high
//  wr_en       in   1      table write strobe (ignored while busy)
//  wr_idx      in   IDX_W  table entry
//  wr_x,wr_y   in   16     position
//  wr_vx,wr_vy in   16     velocity
//  r2_thr      in   16     threshold, sampled on start, driven on chk_r2
//  start       in   1      pulse; ignored while busy
//  busy        out  1      run (or reset drain) in progress
//  done        out  1      1-cycle pulse, run complete
//  res_valid   out  1      1-cycle pulse per evaluated pair
//  res_i,res_j out  IDX_W  pair indices of result
//  res_hit     out  1      checker trial for that pair
//  hit_cnt     out  16     hits this run, cleared on start, saturates at FFFF
//  err         out  1      sticky: out_rdy low when result sampled; cleared on start/reset
//  chk_x1,chk_y1,chk_vx1,chk_vy1  out 16  object i operands
//  chk_x2,chk_y2,chk_vx2,chk_vy2  out 16  object j operands
//  chk_r2      out  16     threshold
//  chk_in_rdy  out  1      checker advance enable
//  chk_trial   in   1      checker result
//  chk_out_rdy in   1      checker result-ready
// BEHAVIOUR
//  Reset: all outputs 0 except chk_in_rdy/phase (see drain); table contents not cleared.
//  Checker contract: executes one 10-step sequence, one step per clock with in_rdy=1, latches operands on step 0,
//   trial/out_rdy valid from cycle after step 9; in_rdy=0 freezes it. Scheduler mirrors with phase counter 0..9,
//   incremented on every cycle chk_in_rdy=1, wraps 9->0.
//  FSM IDLE -> SEEK -> RUN -> IDLE.
//   IDLE: start in cycle S -> latch r2_thr, clear hit_cnt/err, pair=(0,1), busy=1, SEEK from S+1.
//   SEEK: evaluate current pair; if enabled load chk_* from table at end of cycle, RUN with chk_in_rdy=1 next cycle
//    (cycle L, phase 0); if disabled step to next pair (one pair/cycle); past last pair -> done, IDLE.
//   RUN: at end of phase 9: next enabled pair -> reload chk_* and keep chk_in_rdy=1 (back-to-back, 10 cycles/pair);
//    next disabled -> chk_in_rdy=0, SEEK; no more pairs -> chk_in_rdy=0 (must be 0 at L+10, else checker starts
//    a stray sequence).
//  Result: in cycle L+10 sample chk_trial/chk_out_rdy; res_valid/res_i/res_j/res_hit registered, visible L+11.
//   chk_out_rdy=0 at sample -> err=1 (result still emitted).
//  Pair order: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
//  done pulses with the final res_valid; busy low from that cycle.
//  chk_* operands stable for whole transaction; only change at end of phase 9 or on SEEK load.
//  Reset mid-RUN (phase!=0): drain -- chk_in_rdy held 1 and phase counts until wrap to 0, then chk_in_rdy=0;
//   busy=1 during drain, no res_valid/done; all else reset immediately. Start ignored during drain.
// CONFIGURATION
//  COLL_SCHED_MASK_EN defined: extra port obj_en in N_OBJ, sampled on start; pair enabled iff both bits set;
//   disabled pairs produce no transaction/res_valid, cost 1 SEEK cycle each.
//  Undefined: no obj_en port; all pairs enabled; pure back-to-back RUN after first SEEK.
// TESTING
//  1 N=8 all distinct far-apart objects, start@S -> 28 res_valid, first @S+13, last @S+283, res_hit=0, hit_cnt=0, done@S+283.
//  2 obj 2,5 on collision course, rest far -> only (2,5) res_hit=1, hit_cnt=1; operands on chk_* match table.
//  3 start pulsed while busy, wr_en while busy -> ignored; table/results unchanged.
//  4 reset at phase 4 of pair (1,3) -> chk_in_rdy high 6 more cycles then 0, no res_valid; next run exact timing as test 1.
//  5 stub checker holds out_rdy=0 -> err=1 after first result, stays 1 until next start.
//  6 MASK_EN, obj_en=8'hF0 -> 6 results (4..7 pairs only), order (4,5)..(6,7), done after skipping 22 pairs.

Source files
------------

// File: rtl/coll_pair_sched.sv
// Pair scheduler for coll_det: walks every object pair (i<j) and runs one checker transaction per pair.
// Optional per-object enable mask when COLL_SCHED_MASK_EN is defined.
module coll_pair_sched #(
    parameter int unsigned N_OBJ = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_x,
    input  logic [15:0]      wr_y,
    input  logic [15:0]      wr_vx,
    input  logic [15:0]      wr_vy,
    input  logic [15:0]      r2_thr,
    input  logic             start,
`ifdef COLL_SCHED_MASK_EN
    input  logic [N_OBJ-1:0] obj_en,
`endif
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_i,
    output logic [IDX_W-1:0] res_j,
    output logic             res_hit,
    output logic [15:0]      hit_cnt,
    output logic             err,
    output logic [15:0]      chk_x1,
    output logic [15:0]      chk_y1,
    output logic [15:0]      chk_vx1,
    output logic [15:0]      chk_vy1,
    output logic [15:0]      chk_x2,
    output logic [15:0]      chk_y2,
    output logic [15:0]      chk_vx2,
    output logic [15:0]      chk_vy2,
    output logic [15:0]      chk_r2,
    output logic             chk_in_rdy,
    input  logic             chk_trial,
    input  logic             chk_out_rdy
);

    localparam int unsigned DW      = 16;
    localparam int unsigned PH_W    = 4;
    localparam int unsigned PH_LAST = 9;
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_OBJ - 2);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_OBJ - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEEK = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [DW-1:0] tab_x  [N_OBJ];
    logic [DW-1:0] tab_y  [N_OBJ];
    logic [DW-1:0] tab_vx [N_OBJ];
    logic [DW-1:0] tab_vy [N_OBJ];

    logic [1:0]       state, state_d;
    logic [IDX_W-1:0] cur_i, cur_j, nxt_i, nxt_j, ld_i, ld_j, smp_i, smp_j;
    logic             fin, nxt_fin, cur_en, nxt_en;
    logic [PH_W-1:0]  phase, phase_inc;
    logic             phase_end, drain_d, pend;
    logic             start_acc, finish, load_op, adv;

    // Object table; writes only land while no run or drain is in progress.
    always_ff @(posedge clock) begin
        if (wr_en && !busy && (32'(wr_idx) < N_OBJ)) begin
            tab_x[wr_idx]  <= wr_x;
            tab_y[wr_idx]  <= wr_y;
            tab_vx[wr_idx] <= wr_vx;
            tab_vy[wr_idx] <= wr_vy;
        end
    end

`ifdef COLL_SCHED_MASK_EN
    logic [N_OBJ-1:0] en_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            en_mask <= '0;
        end else if (start_acc) begin
            en_mask <= obj_en;
        end
    end

    assign cur_en = en_mask[cur_i] & en_mask[cur_j];
    assign nxt_en = en_mask[nxt_i] & en_mask[nxt_j];
`else
    assign cur_en = 1'b1;
    assign nxt_en = 1'b1;
`endif

    // Phase mirrors the checker's step counter; it only moves while the checker advances.
    assign phase_end = chk_in_rdy && (phase >= PH_W'(PH_LAST));
    assign phase_inc = phase_end ? '0 : phase + PH_W'(1);
    assign drain_d   = chk_in_rdy && !phase_end;

    // Pair successor in (0,1),(0,2)..(N-2,N-1) order.
    always_comb begin
        nxt_i   = cur_i;
        nxt_j   = cur_j + IDX_W'(1);
        nxt_fin = 1'b0;
        if (cur_j == LAST_J) begin
            if (cur_i == LAST_I) begin
                nxt_fin = 1'b1;
            end else begin
                nxt_i = cur_i + IDX_W'(1);
                nxt_j = cur_i + IDX_W'(2);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        start_acc = 1'b0;
        finish    = 1'b0;
        load_op   = 1'b0;
        adv       = 1'b0;
        ld_i      = cur_i;
        ld_j      = cur_j;
        case (state)
            S_IDLE: begin
                if (start && !chk_in_rdy) begin
                    start_acc = 1'b1;
                    state_d   = S_SEEK;
                end
            end
            S_SEEK: begin
                if (fin) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end else if (cur_en) begin
                    load_op = 1'b1;
                    state_d = S_RUN;
                end else begin
                    adv = 1'b1;
                end
            end
            S_RUN: begin
                if (phase_end) begin
                    adv = 1'b1;
                    if (!nxt_fin && nxt_en) begin
                        load_op = 1'b1;
                        ld_i    = nxt_i;
                        ld_j    = nxt_j;
                    end else begin
                        state_d = S_SEEK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath; on reset a checker sequence already under way is run out to its wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= drain_d;
            chk_in_rdy <= drain_d;
            phase      <= chk_in_rdy ? phase_inc : '0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            res_i      <= '0;
            res_j      <= '0;
            res_hit    <= 1'b0;
            hit_cnt    <= '0;
            err        <= 1'b0;
            pend       <= 1'b0;
            smp_i      <= '0;
            smp_j      <= '0;
            cur_i      <= '0;
            cur_j      <= '0;
            fin        <= 1'b0;
            chk_x1     <= '0;
            chk_y1     <= '0;
            chk_vx1    <= '0;
            chk_vy1    <= '0;
            chk_x2     <= '0;
            chk_y2     <= '0;
            chk_vx2    <= '0;
            chk_vy2    <= '0;
            chk_r2     <= '0;
        end else begin
            done      <= finish;
            res_valid <= pend;
            pend      <= 1'b0;
            if (chk_in_rdy) begin
                phase <= phase_inc;
            end
            if (pend) begin
                res_i   <= smp_i;
                res_j   <= smp_j;
                res_hit <= chk_trial;
                if (!chk_out_rdy) begin
                    err <= 1'b1;
                end
                if (chk_trial && (hit_cnt != 16'hFFFF)) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end
            if (start_acc) begin
                chk_r2  <= r2_thr;
                hit_cnt <= '0;
                err     <= 1'b0;
                cur_i   <= '0;
                cur_j   <= IDX_W'(1);
                fin     <= 1'b0;
                busy    <= 1'b1;
            end
            if ((state == S_IDLE) && chk_in_rdy) begin
                chk_in_rdy <= drain_d;
                busy       <= drain_d;
            end
            if (finish) begin
                busy <= 1'b0;
            end
            if (load_op) begin
                chk_x1     <= tab_x[ld_i];
                chk_y1     <= tab_y[ld_i];
                chk_vx1    <= tab_vx[ld_i];
                chk_vy1    <= tab_vy[ld_i];
                chk_x2     <= tab_x[ld_j];
                chk_y2     <= tab_y[ld_j];
                chk_vx2    <= tab_vx[ld_j];
                chk_vy2    <= tab_vy[ld_j];
                chk_in_rdy <= 1'b1;
            end else if ((state == S_RUN) && phase_end) begin
                chk_in_rdy <= 1'b0;
            end
            if (adv) begin
                cur_i <= nxt_i;
                cur_j <= nxt_j;
                fin   <= nxt_fin;
            end
            // Result for the pair just finished is sampled one cycle after its phase 9.
            if ((state == S_RUN) && phase_end) begin
                smp_i <= cur_i;
                smp_j <= cur_j;
                pend  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coll_pair_sched.sv
// Directed bench for coll_pair_sched with a behavioural 10-step coll_det stub.
module tb_coll_pair_sched;

    localparam int unsigned N_OBJ = 8;
    localparam int unsigned IDX_W = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic wr_en = 1'b0;
    logic start = 1'b0;
    logic [IDX_W-1:0] wr_idx = '0;
    logic [15:0] wr_x = '0, wr_y = '0, wr_vx = '0, wr_vy = '0, r2_thr = 16'd100;
    logic busy, done, res_valid, res_hit, err, chk_in_rdy;
    logic [IDX_W-1:0] res_i, res_j;
    logic [15:0] hit_cnt;
    logic [15:0] chk_x1, chk_y1, chk_vx1, chk_vy1, chk_x2, chk_y2, chk_vx2, chk_vy2, chk_r2;
    logic chk_trial = 1'b0;
    logic chk_out_rdy = 1'b0;
`ifdef COLL_SCHED_MASK_EN
    logic [N_OBJ-1:0] obj_en = 8'hFF;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    coll_pair_sched #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_vx(wr_vx), .wr_vy(wr_vy), .r2_thr(r2_thr),
        .start(start),
`ifdef COLL_SCHED_MASK_EN
        .obj_en(obj_en),
`endif
        .busy(busy), .done(done), .res_valid(res_valid), .res_i(res_i), .res_j(res_j),
        .res_hit(res_hit), .hit_cnt(hit_cnt), .err(err),
        .chk_x1(chk_x1), .chk_y1(chk_y1), .chk_vx1(chk_vx1), .chk_vy1(chk_vy1),
        .chk_x2(chk_x2), .chk_y2(chk_y2), .chk_vx2(chk_vx2), .chk_vy2(chk_vy2),
        .chk_r2(chk_r2), .chk_in_rdy(chk_in_rdy), .chk_trial(chk_trial),
        .chk_out_rdy(chk_out_rdy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Checker stub: 10 steps per sequence, operands latched on step 0, hit if positions after one step are within r2.
    int st_step = 0;
    int stab_err = 0;
    logic bad_rdy = 1'b0;
    logic [127:0] l_ops;
    logic [15:0] l_r2;
    logic [127:0] ops_q[$];

    function automatic logic stub_hit(input logic [127:0] o, input logic [15:0] r2);
        int dx, dy;
        dx = (int'($signed(o[127:112])) + int'($signed(o[95:80])))
           - (int'($signed(o[63:48])) + int'($signed(o[31:16])));
        dy = (int'($signed(o[111:96])) + int'($signed(o[79:64])))
           - (int'($signed(o[47:32])) + int'($signed(o[15:0])));
        return (dx * dx + dy * dy) <= int'(r2);
    endfunction

    always @(posedge clock) begin
        if (chk_in_rdy) begin
            if (st_step == 0) begin
                l_ops = {chk_x1, chk_y1, chk_vx1, chk_vy1, chk_x2, chk_y2, chk_vx2, chk_vy2};
                l_r2  = chk_r2;
                ops_q.push_back(l_ops);
            end else if ({chk_x1, chk_y1, chk_vx1, chk_vy1, chk_x2, chk_y2, chk_vx2, chk_vy2} !== l_ops) begin
                stab_err++;
            end
            if (st_step == 9) begin
                st_step     <= 0;
                chk_trial   <= stub_hit(l_ops, l_r2);
                chk_out_rdy <= !bad_rdy;
            end else begin
                st_step     <= st_step + 1;
                chk_trial   <= 1'b0;
                chk_out_rdy <= 1'b0;
            end
        end
    end

    typedef struct { int i; int j; logic hit; int cyc; } res_t;
    res_t res_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;

    always @(negedge clock) begin
        res_t r;
        if (res_valid) begin
            r.i = int'(res_i); r.j = int'(res_j); r.hit = res_hit; r.cyc = cyc;
            res_q.push_back(r);
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    logic [15:0] tab_x [N_OBJ], tab_y [N_OBJ], tab_vx [N_OBJ], tab_vy [N_OBJ];
    int exp_i[$], exp_j[$];

    function automatic void build_pairs(input logic [7:0] m);
        exp_i.delete(); exp_j.delete();
        for (int i = 0; i < N_OBJ; i++)
            for (int j = i + 1; j < N_OBJ; j++)
                if (m[i] && m[j]) begin exp_i.push_back(i); exp_j.push_back(j); end
    endfunction

    function automatic int order_errs(input int n);
        int e = (res_q.size() != n) ? 1 : 0;
        for (int k = 0; k < n && k < res_q.size(); k++)
            if (res_q[k].i != exp_i[k] || res_q[k].j != exp_j[k]) e++;
        return e;
    endfunction

    function automatic int gap_errs();
        int e = 0;
        for (int k = 1; k < res_q.size(); k++)
            if (res_q[k].cyc - res_q[k-1].cyc != 10) e++;
        return e;
    endfunction

    function automatic int ops_errs();
        int e = (ops_q.size() != exp_i.size()) ? 1 : 0;
        for (int k = 0; k < ops_q.size() && k < exp_i.size(); k++)
            if (ops_q[k] !== {tab_x[exp_i[k]], tab_y[exp_i[k]], tab_vx[exp_i[k]], tab_vy[exp_i[k]],
                              tab_x[exp_j[k]], tab_y[exp_j[k]], tab_vx[exp_j[k]], tab_vy[exp_j[k]]}) e++;
        return e;
    endfunction

    function automatic int wrong_hits(input int hi, input int hj);
        int e = 0;
        for (int k = 0; k < res_q.size(); k++)
            if (res_q[k].hit !== ((res_q[k].i == hi) && (res_q[k].j == hj))) e++;
        return e;
    endfunction

    function automatic int first_cyc();
        return (res_q.size() > 0) ? res_q[0].cyc : -1;
    endfunction

    function automatic int last_cyc();
        return (res_q.size() > 0) ? res_q[res_q.size()-1].cyc : -1;
    endfunction

    task automatic write_obj(input int idx, input logic [15:0] x, y, vx, vy, input bit model);
        @(posedge clock); #1;
        wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_x = x; wr_y = y; wr_vx = vx; wr_vy = vy;
        @(posedge clock); #1;
        wr_en = 1'b0;
        if (model) begin tab_x[idx] = x; tab_y[idx] = y; tab_vx[idx] = vx; tab_vy[idx] = vy; end
    endtask

    task automatic pulse_start(output int s);
        res_q.delete(); ops_q.delete();
        @(posedge clock); #1;
        start = 1'b1; s = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int n = 0; n < 600 && done_cnt == d0; n++) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (20) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL reset_hit_cnt got=%0d want=0", hit_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (chk_in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b want=0", chk_in_rdy); end
        checks++; if (chk_r2 !== 16'd0) begin failures++; $display("FAIL reset_chk_r2 got=%0d want=0", chk_r2); end
    endtask

    task automatic load_far();
        for (int i = 0; i < N_OBJ; i++) write_obj(i, 16'(i * 1000), 16'(i * 300), 16'd0, 16'd0, 1'b1);
    endtask

    task automatic test_far();
        int s, d0;
        build_pairs(8'hFF); d0 = done_cnt;
        pulse_start(s); wait_done(d0);
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL far_done_cnt got=%0d want=%0d", done_cnt, d0 + 1); end
        checks++; if (order_errs(28) !== 0) begin failures++; $display("FAIL far_order got=%0d results want=28 in order", res_q.size()); end
        checks++; if (first_cyc() !== s + 13) begin failures++; $display("FAIL far_first got=%0d want=%0d", first_cyc(), s + 13); end
        checks++; if (last_cyc() !== s + 283) begin failures++; $display("FAIL far_last got=%0d want=%0d", last_cyc(), s + 283); end
        checks++; if (done_cyc !== s + 283) begin failures++; $display("FAIL far_done_cyc got=%0d want=%0d", done_cyc, s + 283); end
        checks++; if (done_busy !== 1'b0) begin failures++; $display("FAIL far_busy_at_done got=%b want=0", done_busy); end
        checks++; if (gap_errs() !== 0) begin failures++; $display("FAIL far_spacing got=%0d bad gaps want=0", gap_errs()); end
        checks++; if (wrong_hits(-1, -1) !== 0) begin failures++; $display("FAIL far_hits got=%0d want=0", wrong_hits(-1, -1)); end
        checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL far_hit_cnt got=%0d want=0", hit_cnt); end
        checks++; if (ops_errs() !== 0) begin failures++; $display("FAIL far_operands got=%0d bad want=0", ops_errs()); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL far_stable got=%0d want=0", stab_err); end
        checks++; if (chk_r2 !== 16'd100) begin failures++; $display("FAIL far_chk_r2 got=%0d want=100", chk_r2); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL far_err got=%b want=0", err); end
    endtask

    task automatic test_collision();
        int s, d0;
        write_obj(2, 16'd2000, 16'd600, 16'd1500, 16'd450, 1'b1);
        write_obj(5, 16'd5000, 16'd1500, 16'(-1500), 16'(-450), 1'b1);
        build_pairs(8'hFF); d0 = done_cnt;
        pulse_start(s); wait_done(d0);
        checks++; if (order_errs(28) !== 0) begin failures++; $display("FAIL coll_order got=%0d results want=28 in order", res_q.size()); end
        checks++; if (wrong_hits(2, 5) !== 0) begin failures++; $display("FAIL coll_hits got=%0d wrong want=0", wrong_hits(2, 5)); end
        checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL coll_hit_cnt got=%0d want=1", hit_cnt); end
        checks++; if (ops_errs() !== 0) begin failures++; $display("FAIL coll_operands got=%0d bad want=0", ops_errs()); end
        checks++; if (last_cyc() !== s + 283) begin failures++; $display("FAIL coll_last got=%0d want=%0d", last_cyc(), s + 283); end
    endtask

    task automatic test_busy_ignore();
        int s, d0;
        d0 = done_cnt;
        pulse_start(s);
        repeat (28) @(posedge clock);
        #1 start = 1'b1; wr_en = 1'b1; wr_idx = '0; wr_x = 16'd12345;
        @(posedge clock); #1 start = 1'b0; wr_en = 1'b0;
        wait_done(d0);
        repeat (30) @(negedge clock);
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL busy_done_cnt got=%0d want=%0d", done_cnt, d0 + 1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_restart got=%b want=0", busy); end
        checks++; if (order_errs(28) !== 0) begin failures++; $display("FAIL busy_order got=%0d results want=28 in order", res_q.size()); end
        checks++; if (ops_errs() !== 0) begin failures++; $display("FAIL busy_table got=%0d bad operands want=0", ops_errs()); end
        checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL busy_hit_cnt got=%0d want=1", hit_cnt); end
        checks++; if (last_cyc() !== s + 283) begin failures++; $display("FAIL busy_last got=%0d want=%0d", last_cyc(), s + 283); end
    endtask

    task automatic test_reset_drain();
        int s, d0, rdy_hi, busy_hi;
        d0 = done_cnt;
        pulse_start(s);
        repeat (85) @(posedge clock);
        #1 reset = 1'b1;
        rdy_hi = 0; busy_hi = 0;
        @(negedge clock); if (chk_in_rdy) rdy_hi++;
        @(posedge clock); #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (chk_in_rdy) rdy_hi++;
            if (busy) busy_hi++;
            start = (k == 1);
        end
        start = 1'b0;
        @(negedge clock);
        checks++; if (rdy_hi !== 6) begin failures++; $display("FAIL drain_rdy_cycles got=%0d want=6", rdy_hi); end
        checks++; if (busy_hi !== 5) begin failures++; $display("FAIL drain_busy_cycles got=%0d want=5", busy_hi); end
        checks++; if (chk_in_rdy !== 1'b0) begin failures++; $display("FAIL drain_end_rdy got=%b want=0", chk_in_rdy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_end_busy got=%b want=0", busy); end
        repeat (40) @(negedge clock);
        checks++; if (order_errs(8) !== 0) begin failures++; $display("FAIL drain_results got=%0d want=8 in order", res_q.size()); end
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL drain_done got=%0d want=%0d", done_cnt, d0); end
        checks++; if (st_step !== 0) begin failures++; $display("FAIL drain_checker_step got=%0d want=0", st_step); end
        checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL drain_hit_cnt got=%0d want=0", hit_cnt); end
        d0 = done_cnt;
        pulse_start(s); wait_done(d0);
        checks++; if (order_errs(28) !== 0) begin failures++; $display("FAIL rerun_order got=%0d results want=28 in order", res_q.size()); end
        checks++; if (first_cyc() !== s + 13) begin failures++; $display("FAIL rerun_first got=%0d want=%0d", first_cyc(), s + 13); end
        checks++; if (last_cyc() !== s + 283) begin failures++; $display("FAIL rerun_last got=%0d want=%0d", last_cyc(), s + 283); end
        checks++; if (done_cyc !== s + 283) begin failures++; $display("FAIL rerun_done got=%0d want=%0d", done_cyc, s + 283); end
    endtask

    task automatic test_err();
        int s, d0;
        bad_rdy = 1'b1; d0 = done_cnt;
        pulse_start(s);
        for (int n = 0; n < 50 && cyc != s + 12; n++) @(negedge clock);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_before got=%b want=0", err); end
        @(negedge clock);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_first got=%b want=1", err); end
        wait_done(d0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
        checks++; if (res_q.size() !== 28) begin failures++; $display("FAIL err_results got=%0d want=28", res_q.size()); end
        bad_rdy = 1'b0; d0 = done_cnt;
        pulse_start(s);
        @(negedge clock);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", err); end
        wait_done(d0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clean_run got=%b want=0", err); end
    endtask

`ifdef COLL_SCHED_MASK_EN
    task automatic test_mask();
        int s, d0;
        obj_en = 8'hF0; build_pairs(8'hF0); d0 = done_cnt;
        pulse_start(s); wait_done(d0);
        obj_en = 8'hFF;
        checks++; if (order_errs(6) !== 0) begin failures++; $display("FAIL mask_order got=%0d results want=6 in order", res_q.size()); end
        checks++; if (first_cyc() !== s + 35) begin failures++; $display("FAIL mask_first got=%0d want=%0d", first_cyc(), s + 35); end
        checks++; if (last_cyc() !== s + 85) begin failures++; $display("FAIL mask_last got=%0d want=%0d", last_cyc(), s + 85); end
        checks++; if (done_cyc !== s + 85) begin failures++; $display("FAIL mask_done got=%0d want=%0d", done_cyc, s + 85); end
        checks++; if (ops_errs() !== 0) begin failures++; $display("FAIL mask_operands got=%0d bad want=0", ops_errs()); end
        checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL mask_hit_cnt got=%0d want=0", hit_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        load_far();
        test_far();
        test_collision();
        test_busy_ignore();
        test_reset_drain();
        test_err();
`ifdef COLL_SCHED_MASK_EN
        test_mask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
